bram_1r1w_be: RTL and testbench

BRAM_1R1W_BE -- requirements
Module: bram_1r1w_be

---
 rtl/bram_1r1w_be.sv | 93 +++++++++
 tb/tb_bram_1r1w_be.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bram_1r1w_be.sv
// Simple dual-port block RAM: one write port with per-lane byte enables, one read port,
// selectable read-during-write policy and optional output pipeline register.
module bram_1r1w_be #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("bram_1r1w_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // Memory is deliberately left out of reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    r_mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign w_collide = rd_en & wr_en & (rd_addr == wr_addr);

    // Write-first bypass: enabled write lanes override the stored word on a collision.
    always_comb begin
        w_rd_word = r_mem[rd_addr];
        if (RDW_MODE == 0 && w_collide) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] r_s2_data;
        logic                  r_s2_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_data  <= '0;
                r_s2_valid <= 1'b0;
            end else begin
                r_s2_data  <= r_rd_data;
                r_s2_valid <= r_rd_valid;
            end
        end

        assign rd_data  = r_s2_data;
        assign rd_valid = r_s2_valid;
    end else begin : g_no_out_reg
        assign rd_data  = r_rd_data;
        assign rd_valid = r_rd_valid;
    end

endmodule

// File: tb/tb_bram_1r1w_be.sv
// Directed bench: two instances share stimulus; u0 is write-first with LAT=1,
// u1 is read-first with LAT=2.
module tb_bram_1r1w_be;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;

    int n_pass  = 0;
    int n_total = 0;

    bram_1r1w_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .RDW_MODE(0), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    bram_1r1w_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .RDW_MODE(1), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_be = 4'h0; wr_addr = 4'h0; wr_data = 32'h0;
        rd_en = 1'b0; rd_addr = 4'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        idle();
    endtask

    // Issue one read (optionally with a concurrent write) and check both latencies.
    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic do_wr, input logic [3:0] wa, input logic [31:0] wd,
                          input logic [3:0] wbe,
                          input logic [31:0] exp0, input logic [31:0] exp1);
        rd_en = 1'b1; rd_addr = a;
        wr_en = do_wr; wr_addr = wa; wr_data = wd; wr_be = wbe;
        tick();
        idle();
        chk({tag, "_u0_valid"}, {31'b0, rd_valid0}, 32'd1);
        chk({tag, "_u0_data"}, rd_data0, exp0);
        chk({tag, "_u1_valid_early"}, {31'b0, rd_valid1}, 32'd0);
        tick();
        chk({tag, "_u0_valid_drop"}, {31'b0, rd_valid0}, 32'd0);
        chk({tag, "_u0_data_hold"}, rd_data0, exp0);
        chk({tag, "_u1_valid"}, {31'b0, rd_valid1}, 32'd1);
        chk({tag, "_u1_data"}, rd_data1, exp1);
        tick();
        chk({tag, "_u1_valid_drop"}, {31'b0, rd_valid1}, 32'd0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_u0_valid", {31'b0, rd_valid0}, 32'd0);
        chk("rst_u0_data", rd_data0, 32'h0);
        chk("rst_u1_valid", {31'b0, rd_valid1}, 32'd0);
        chk("rst_u1_data", rd_data1, 32'h0);
        rst = 1'b0;

        for (int a = 0; a < 16; a++) begin
            wr(4'(a), 32'(a) * 32'h01010101, 4'hF);
        end

        // Streaming 17 back-to-back reads: 0..15 then wrap to 0.
        for (int t = 0; t < 17; t++) begin
            rd_en = 1'b1; rd_addr = 4'(t);
            tick();
            chk($sformatf("stream%0d_u0_valid", t), {31'b0, rd_valid0}, 32'd1);
            chk($sformatf("stream%0d_u0_data", t), rd_data0, 32'(t & 15) * 32'h01010101);
            if (t == 0) begin
                chk("stream0_u1_valid", {31'b0, rd_valid1}, 32'd0);
            end else begin
                chk($sformatf("stream%0d_u1_valid", t), {31'b0, rd_valid1}, 32'd1);
                chk($sformatf("stream%0d_u1_data", t), rd_data1, 32'((t - 1) & 15) * 32'h01010101);
            end
        end
        idle();
        tick();
        chk("stream_drain_u0_valid", {31'b0, rd_valid0}, 32'd0);
        chk("stream_drain_u0_hold", rd_data0, 32'h0);
        chk("stream_last_u1_valid", {31'b0, rd_valid1}, 32'd1);
        chk("stream_last_u1_data", rd_data1, 32'h0);
        tick();
        chk("stream_drain_u1_valid", {31'b0, rd_valid1}, 32'd0);
        chk("stream_drain_u1_hold", rd_data1, 32'h0);

        wr(4'd3, 32'hAABBCCDD, 4'hF);
        wr(4'd3, 32'h11223344, 4'h5);
        rd_chk("be_merge", 4'd3, 1'b0, 4'd0, 32'h0, 4'h0, 32'hAA22CC44, 32'hAA22CC44);

        wr(4'd4, 32'hFFFFFFFF, 4'h0);
        rd_chk("be_zero_noop", 4'd4, 1'b0, 4'd0, 32'h0, 4'h0, 32'h04040404, 32'h04040404);

        wr(4'd5, 32'h00000000, 4'hF);
        rd_chk("coll_partial", 4'd5, 1'b1, 4'd5, 32'hDEADBEEF, 4'h3, 32'h0000BEEF, 32'h00000000);
        rd_chk("coll_partial_after", 4'd5, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0000BEEF, 32'h0000BEEF);

        wr(4'd5, 32'h12345678, 4'hF);
        rd_chk("coll_full", 4'd5, 1'b1, 4'd5, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 32'h12345678);
        rd_chk("coll_full_after", 4'd5, 1'b0, 4'd0, 32'h0, 4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);

        wr(4'd2, 32'h00000009, 4'hF);
        rd_chk("diff_addr", 4'd2, 1'b1, 4'd1, 32'h00000005, 4'hF, 32'h00000009, 32'h00000009);
        rd_chk("diff_addr_later", 4'd1, 1'b0, 4'd0, 32'h0, 4'h0, 32'h00000005, 32'h00000005);

        // Reset with a read in flight; the write attempted under reset must be suppressed.
        rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hDEADDEAD; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        chk("midrst_u0_valid", {31'b0, rd_valid0}, 32'd0);
        chk("midrst_u0_data", rd_data0, 32'h0);
        chk("midrst_u1_valid", {31'b0, rd_valid1}, 32'd0);
        chk("midrst_u1_data", rd_data1, 32'h0);
        rst = 1'b0;
        idle();
        tick();
        chk("postrst_u1_valid", {31'b0, rd_valid1}, 32'd0);
        chk("postrst_u1_data", rd_data1, 32'h0);
        rd_chk("postrst_read", 4'd2, 1'b0, 4'd0, 32'h0, 4'h0, 32'h00000009, 32'h00000009);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
